// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared constants and state encoding for the 4-requester register arbiter
package arbitro_pkg;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CARGA    = 2'd1,
    CONFIRMA = 2'd2,
    ESPERA   = 2'd3
  } estado_t;
endpackage

// File: rtl/arbitro_registrador_seletor_rr.sv
// seletor_rr: combinational round-robin pick of the first active request at or after ptr (req, ptr -> found, winner)
module seletor_rr
  import arbitro_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      winner
);
  always_comb begin
    winner = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
  end
  assign found = |req;
endmodule

// File: rtl/arbitro_registrador.sv
// arbitro_registrador: round-robin arbiter loading one of 4 requesters into a shared register (clock, reset, req, data_in, ler -> ack, Q, valid, owner, busy, db_estado)
module arbitro_registrador
  import arbitro_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] data_in,
  input  logic              ler,
  output logic [NREQ-1:0]   ack,
  output logic [N-1:0]      Q,
  output logic              valid,
  output logic [1:0]        owner,
  output logic              busy,
  output logic [1:0]        db_estado
);
  estado_t        estado_q;
  logic [N-1:0]   q_q;
  logic           valid_q;
  logic [1:0]     owner_q;
  logic [1:0]     grant_q;
  logic [1:0]     ptr_q;
  logic           found;
  logic [1:0]     winner;
  seletor_rr u_sel (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .winner(winner)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      q_q      <= '0;
      valid_q  <= 1'b0;
      owner_q  <= 2'd0;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      if (ler && valid_q) valid_q <= 1'b0;
      case (estado_q)
        OCIOSO:
          if (found && (!valid_q || ler)) begin
            grant_q  <= winner;
            estado_q <= CARGA;
          end
        CARGA: begin
          // load overrides a simultaneous read strobe
          q_q      <= data_in[grant_q*N +: N];
          owner_q  <= grant_q;
          valid_q  <= 1'b1;
          estado_q <= CONFIRMA;
        end
        CONFIRMA: estado_q <= ESPERA;
        ESPERA:
          if (!req[grant_q]) begin
            ptr_q    <= grant_q + 2'd1;
            estado_q <= OCIOSO;
          end
      endcase
    end
  end
  assign ack       = (estado_q == CONFIRMA) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign Q         = q_q;
  assign valid     = valid_q;
  assign owner     = owner_q;
  assign busy      = estado_q != OCIOSO;
  assign db_estado = estado_q;
endmodule

// File: tb/tb_arbitro_registrador.sv
// tb_arbitro_registrador: directed-vector bench for arbitro_registrador with N=8
module tb_arbitro_registrador;
  localparam int N = 8;
  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*N-1:0] data_in;
  logic          ler;
  logic [3:0]    ack;
  logic [N-1:0]  Q;
  logic          valid;
  logic [1:0]    owner;
  logic          busy;
  logic [1:0]    db_estado;
  int vectors = 0;
  int miscompares = 0;
  arbitro_registrador #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .ler      (ler),
    .ack      (ack),
    .Q        (Q),
    .valid    (valid),
    .owner    (owner),
    .busy     (busy),
    .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk_idle_reset(input string tag);
    chk({tag, " state"}, 32'(db_estado), 0);
    chk({tag, " Q"}, 32'(Q), 0);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " owner"}, 32'(owner), 0);
    chk({tag, " ack"}, 32'(ack), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask
  initial begin
    reset = 1'b1;
    req = '0;
    data_in = '0;
    ler = 1'b0;
    step();
    reset = 1'b0;
    chk_idle_reset("rst");
    // single transfer from requester 0
    req = 4'b0001;
    data_in[7:0] = 8'hA5;
    step();
    chk("single carga", 32'(db_estado), 1);
    chk("single busy1", 32'(busy), 1);
    chk("single noack", 32'(ack), 0);
    step();
    chk("single ack", 32'(ack), 4'b0001);
    chk("single Q", 32'(Q), 8'hA5);
    chk("single valid", 32'(valid), 1);
    chk("single owner", 32'(owner), 0);
    chk("single busy2", 32'(busy), 1);
    req = 4'b0000;
    step();
    chk("single espera", 32'(db_estado), 3);
    chk("single ack off", 32'(ack), 0);
    chk("single busy3", 32'(busy), 1);
    step();
    chk("single idle", 32'(db_estado), 0);
    chk("single busy off", 32'(busy), 0);
    // backpressure: valid=1, no read strobe
    req = 4'b0010;
    data_in[15:8] = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp state", 32'(db_estado), 0);
      chk("bp ack", 32'(ack), 0);
    end
    ler = 1'b1;
    step();
    ler = 1'b0;
    chk("bp carga", 32'(db_estado), 1);
    chk("bp valid cleared", 32'(valid), 0);
    chk("bp Q held", 32'(Q), 8'hA5);
    step();
    chk("bp ack", 32'(ack), 4'b0010);
    chk("bp Q", 32'(Q), 8'h3C);
    chk("bp owner", 32'(owner), 1);
    chk("bp valid", 32'(valid), 1);
    req = 4'b0000;
    step();
    step();
    chk("bp idle", 32'(db_estado), 0);
    // read-through grant, then ler during CARGA
    req = 4'b0100;
    data_in[23:16] = 8'h5A;
    ler = 1'b1;
    step();
    chk("sim readthrough", 32'(db_estado), 1);
    step();
    ler = 1'b0;
    chk("sim valid kept", 32'(valid), 1);
    chk("sim Q", 32'(Q), 8'h5A);
    chk("sim ack", 32'(ack), 4'b0100);
    chk("sim owner", 32'(owner), 2);
    req = 4'b0000;
    step();
    step();
    chk("sim idle", 32'(db_estado), 0);
    chk("sim valid idle", 32'(valid), 1);
    // fairness from ptr=0
    reset = 1'b1;
    step();
    reset = 1'b0;
    data_in = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111;
      ler = 1'b1;
      step();
      step();
      chk("fair ack", 32'(ack), 32'(1) << (k % 4));
      chk("fair owner", 32'(owner), 32'(k % 4));
      chk("fair Q", 32'(Q), 32'(8'h11 * ((k % 4) + 1)));
      req[k % 4] = 1'b0;
      step();
      step();
      chk("fair idle", 32'(db_estado), 0);
    end
    req = 4'b0000;
    ler = 1'b0;
    // reset during CARGA discards the transfer
    data_in[23:16] = 8'h77;
    req = 4'b0001;
    step();
    chk("rmid carga", 32'(db_estado), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_reset("rmid");
    req = 4'b0100;
    step();
    chk("rmid carga2", 32'(db_estado), 1);
    step();
    chk("rmid ack", 32'(ack), 4'b0100);
    chk("rmid owner", 32'(owner), 2);
    chk("rmid Q", 32'(Q), 8'h77);
    req = 4'b0000;
    step();
    step();
    chk("rmid idle", 32'(db_estado), 0);
    // late drop of req[3]
    data_in[31:24] = 8'hC3;
    req = 4'b1000;
    ler = 1'b1;
    step();
    ler = 1'b0;
    step();
    chk("late ack", 32'(ack), 4'b1000);
    chk("late Q", 32'(Q), 8'hC3);
    req = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("late espera", 32'(db_estado), 3);
      chk("late noack", 32'(ack), 0);
    end
    req = 4'b0001;
    step();
    chk("late idle", 32'(db_estado), 0);
    chk("late valid", 32'(valid), 1);
    req = 4'b1001;
    step();
    chk("late blocked", 32'(db_estado), 0);
    ler = 1'b1;
    step();
    ler = 1'b0;
    chk("late carga", 32'(db_estado), 1);
    step();
    chk("late regrant", 32'(ack), 4'b0001);
    chk("late owner", 32'(owner), 0);
    chk("late Q0", 32'(Q), 8'h11);
    req = 4'b0000;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arbitro_registrador.md
ARBITRO_REGISTRADOR -- requirements
Module: arbitro_registrador

Interface
REQ-001 Parameter: N, default 8, data width of the shared register.
REQ-002 Requester count fixed at 4; not a parameter.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  4  request per requester i; held high until ack[i] is seen, then dropped.
REQ-006 data_in  in  4*N  requester i data at bits [i*N+N-1 : i*N]; stable while req[i]=1.
REQ-007 ler  in  1  consumer read strobe; clears valid.
REQ-008 ack  out  4  one-hot, single-cycle load acknowledge.
REQ-009 Q  out  N  shared register contents.
REQ-010 valid  out  1  Q holds unread data.
REQ-011 owner  out  2  index of the requester whose data is in Q.
REQ-012 busy  out  1  high whenever the FSM is not OCIOSO.
REQ-013 db_estado  out  2  current state code, for debug.

Function
REQ-014 FSM states and codes: OCIOSO=0, CARGA=1, CONFIRMA=2, ESPERA=3.
REQ-015 OCIOSO: if req!=0 and (valid=0 or ler=1), latch the winner into grant_id and go to CARGA; otherwise stay.
REQ-016 Winner is the first requester with req high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-017 CARGA: Q<=data_in slice[grant_id], owner<=grant_id, valid<=1; go to CONFIRMA unconditionally.
REQ-018 A load is committed once CARGA is entered, even if req[grant_id] drops during CARGA.
REQ-019 CONFIRMA: ack[grant_id]=1 for exactly this cycle, all other ack bits 0; go to ESPERA.
REQ-020 ESPERA: stay while req[grant_id]=1; when it is 0, set ptr<=grant_id+1 (mod 4) and go to OCIOSO.
REQ-021 ack is decoded from state and grant_id; it is never high outside CONFIRMA.
REQ-022 Latency: request accepted in OCIOSO in cycle t -> Q, valid and owner updated and ack high in cycle t+2; earliest re-grant in cycle t+4.
REQ-023 ler=1 with valid=1 in a non-CARGA cycle -> valid=0 next cycle.
REQ-024 ler while valid=0 has no effect.
REQ-025 ler in a CARGA cycle: the load wins and valid remains 1.
REQ-026 Backpressure: while valid=1 and ler=0, no grant is issued and requesters wait in OCIOSO.
REQ-027 ler=1 with a pending req in OCIOSO grants in that same cycle (read-through).
REQ-028 Q and owner hold their value when no load occurs; ler does not alter them.
REQ-029 grant_id and ptr are 2-bit and wrap 3->0.

Reset
REQ-030 reset=1 at a clock edge: state=OCIOSO, Q=0, valid=0, owner=0, grant_id=0, ptr=0, ack=0, busy=0, db_estado=0.
REQ-031 reset overrides every other input in every state, including mid-CARGA and mid-ESPERA; an interrupted transfer is discarded and gets no ack.

Structure
REQ-032 State codes and the requester count (4) are defined as constants in a shared package, arbitro_pkg.
REQ-033 Round-robin winner selection (inputs req, ptr; outputs found, winner) is one combinational sub-module, seletor_rr.
REQ-034 Data register, valid flag, pointer and FSM reside in arbitro_registrador; no other sub-modules.

Verification (N=8)
REQ-035 Single: reset, then req=0001 with data_in[7:0]=0xA5 -> ack=0001 two cycles later; Q=0xA5, valid=1, owner=0; busy high for 3 cycles after acceptance, plus ESPERA.
REQ-036 Fairness: req=1111 held and re-raised after each ack, ler pulsed after each load -> owner sequence 0,1,2,3,0; no requester granted twice before all others are granted once.
REQ-037 Backpressure: valid=1, ler=0, req=0010 -> no ack for 10 cycles, state stays OCIOSO; ler=1 for one cycle -> ack=0010 two cycles later.
REQ-038 Simultaneous: ler=1 in a CARGA cycle -> valid stays 1 and Q holds the new data; in OCIOSO with valid=1 and pending req, ler=1 -> same-cycle grant.
REQ-039 Reset mid-op: reset asserted in CARGA -> next cycle all outputs 0 with no ack; a subsequent req=0100 grants requester 2 (ptr=0).
REQ-040 Late drop: req[3] held 5 cycles past ack -> FSM stays in ESPERA and no new grant; after the drop, ptr=0 and a pending req=1001 grants requester 0.
